// File: rtl/fir_interp_pkg.sv
// Shared types and helpers for the FIR interpolation controller.
//   fir_state_e : controller FSM state (IDLE waits for a sample, EMIT
//                 presents the L slots of the current sample).
//   clamp_l     : maps the raw upsample request onto the legal 1..max_l range.
package fir_interp_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } fir_state_e;

  // L=0 would mean "no slots", which would swallow samples, so it is treated as 1.
  function automatic int unsigned clamp_l(input int unsigned l, input int unsigned max_l);
    if (l == 0)     return 1;
    if (l > max_l)  return max_l;
    return l;
  endfunction

endpackage

// File: rtl/fir_interp_ctrl_if.sv
// Streaming bus between upstream source, interpolation controller and FIR.
//   s_data/s_valid/s_ready : upstream sample handshake (source -> controller)
//   m_data/m_valid/m_ready : slot handshake (controller -> FIR)
// modport slave  : controller view
// modport master : environment view (drives samples, consumes slots)
interface fir_interp_ctrl_if #(
  parameter int W = 16
);
  logic [W-1:0] s_data;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready;

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid
  );

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid
  );
endinterface

// File: rtl/fir_coeff_bank.sv
// Double-buffered FIR coefficient storage.
// Writes always land in the shadow bank; a commit request is held pending
// until the controller signals a sample boundary, at which point the whole
// shadow bank is copied to the active bank so a sample never sees a mix of
// old and new taps.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   i_wr_en/i_wr_addr/i_wr_data : shadow write port (addr >= N_COEFFS ignored)
//   i_commit                 : one-cycle swap request
//   i_boundary               : controller is at a sample boundary this cycle
//   o_coeff                  : active bank, straight from registers
module fir_coeff_bank #(
  parameter int COEFF_WORD_SIZE = 16,
  parameter int N_COEFFS        = 5,
  localparam int AW             = $clog2(N_COEFFS)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      i_wr_en,
  input  logic [AW-1:0]                             i_wr_addr,
  input  logic [COEFF_WORD_SIZE-1:0]                i_wr_data,
  input  logic                                      i_commit,
  input  logic                                      i_boundary,
  output logic signed [N_COEFFS-1:0][COEFF_WORD_SIZE-1:0] o_coeff
);

  logic [N_COEFFS-1:0][COEFF_WORD_SIZE-1:0] r_shadow;
  logic [N_COEFFS-1:0][COEFF_WORD_SIZE-1:0] r_active;
  logic                                     r_pending;
  logic                                     w_swap;

  // A commit arriving on the boundary cycle itself swaps immediately.
  assign w_swap = i_boundary & (r_pending | i_commit);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
    end else begin
      if (i_wr_en && (32'(i_wr_addr) < N_COEFFS))
        r_shadow[i_wr_addr] <= i_wr_data;
      // Non-blocking copy: a same-cycle write is not part of this swap.
      if (w_swap)
        r_active <= r_shadow;
      if (w_swap)
        r_pending <= 1'b0;
      else if (i_commit)
        r_pending <= 1'b1;
    end
  end

  assign o_coeff = r_active;

endmodule

// File: rtl/fir_interp_ctrl.sv
// Zero-stuffing interpolation controller in front of a FIR.
// Each accepted sample is expanded into L_eff slots: slot 0 carries the
// sample, the rest carry zero. The next sample may be accepted on the
// handshake of the last slot so the FIR sees no bubble.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   cfg_l           : requested upsample factor (clamped to 1..MAX_L)
//   cfg_bypass      : FIR bypass request, latched per sample
//   coef_wr_*       : shadow coefficient write port
//   coef_commit     : request shadow->active swap at next sample boundary
//   bus             : sample in / slot out handshakes
//   fir_coeff       : active coefficient bank
//   fir_bypass      : bypass in effect for the current sample
//   busy, phase     : in EMIT / current slot index
module fir_interp_ctrl
  import fir_interp_pkg::*;
#(
  parameter int INPUT_WORD_SIZE = 16,
  parameter int COEFF_WORD_SIZE = 16,
  parameter int N_COEFFS        = 5,
  parameter int MAX_L           = 8,
  localparam int LW             = $clog2(MAX_L + 1),
  localparam int AW             = $clog2(N_COEFFS)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [LW-1:0]                              cfg_l,
  input  logic                                       cfg_bypass,
  input  logic                                       coef_wr_en,
  input  logic [AW-1:0]                              coef_wr_addr,
  input  logic [COEFF_WORD_SIZE-1:0]                 coef_wr_data,
  input  logic                                       coef_commit,
  fir_interp_ctrl_if.slave                           bus,
  output logic signed [N_COEFFS-1:0][COEFF_WORD_SIZE-1:0] fir_coeff,
  output logic                                       fir_bypass,
  output logic                                       busy,
  output logic [LW-1:0]                              phase
);

  fir_state_e                 r_state, w_state_nxt;
  logic [LW-1:0]              r_phase, w_phase_nxt;
  logic [LW-1:0]              r_leff;
  logic [INPUT_WORD_SIZE-1:0] r_sample;
  logic                       r_bypass;

  logic [LW-1:0]              w_leff_in;
  logic                       w_last;
  logic                       w_accept;
  logic                       w_boundary;

  assign w_leff_in = LW'(clamp_l(32'(cfg_l), MAX_L));
  assign w_last    = (r_phase == r_leff - LW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_phase  <= '0;
      r_leff   <= LW'(1);
      r_sample <= '0;
      r_bypass <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      if (w_accept) begin
        r_sample <= bus.s_data;
        r_leff   <= w_leff_in;
        r_bypass <= cfg_bypass;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_accept    = 1'b0;
    w_boundary  = 1'b0;
    bus.s_ready = 1'b0;
    bus.m_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.s_ready = 1'b1;
        w_boundary  = 1'b1;
        if (bus.s_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_EMIT;
          w_phase_nxt = '0;
        end
      end
      ST_EMIT: begin
        bus.m_valid = 1'b1;
        if (w_last) begin
          // Ready is passed through so a new sample lands exactly when
          // the FIR takes the last slot of the current one.
          bus.s_ready = bus.m_ready;
          if (bus.m_ready) begin
            w_boundary  = 1'b1;
            w_phase_nxt = '0;
            if (bus.s_valid) w_accept    = 1'b1;
            else             w_state_nxt = ST_IDLE;
          end
        end else if (bus.m_ready) begin
          w_phase_nxt = r_phase + LW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.m_data = (r_state == ST_EMIT && r_phase == '0) ? r_sample : '0;
  assign fir_bypass = r_bypass;
  assign busy       = (r_state == ST_EMIT);
  assign phase      = r_phase;

  fir_coeff_bank #(
    .COEFF_WORD_SIZE (COEFF_WORD_SIZE),
    .N_COEFFS        (N_COEFFS)
  ) u_bank (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (coef_wr_en),
    .i_wr_addr  (coef_wr_addr),
    .i_wr_data  (coef_wr_data),
    .i_commit   (coef_commit),
    .i_boundary (w_boundary),
    .o_coeff    (fir_coeff)
  );

endmodule

// File: tb/tb_fir_interp_ctrl.sv
// Directed bench for fir_interp_ctrl: stimulus pushes expected slots into a
// queue, an independent monitor pops and compares on every slot handshake.
module tb_fir_interp_ctrl;
  import fir_interp_pkg::*;

  localparam int W  = 16;
  localparam int CW = 16;
  localparam int N  = 5;
  localparam int ML = 8;
  localparam int LW = 4;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [LW-1:0] cfg_l = '0;
  logic cfg_bypass = 1'b0;
  logic coef_wr_en = 1'b0;
  logic [AW-1:0] coef_wr_addr = '0;
  logic [CW-1:0] coef_wr_data = '0;
  logic coef_commit = 1'b0;
  logic [N-1:0][CW-1:0] fir_coeff;
  logic fir_bypass, busy;
  logic [LW-1:0] phase;

  fir_interp_ctrl_if #(.W(W)) bus ();

  fir_interp_ctrl #(
    .INPUT_WORD_SIZE(W), .COEFF_WORD_SIZE(CW), .N_COEFFS(N), .MAX_L(ML)
  ) dut (
    .clk(clk), .rst(rst), .cfg_l(cfg_l), .cfg_bypass(cfg_bypass),
    .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr),
    .coef_wr_data(coef_wr_data), .coef_commit(coef_commit),
    .bus(bus), .fir_coeff(fir_coeff), .fir_bypass(fir_bypass),
    .busy(busy), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  data;
    logic [LW-1:0] ph;
    logic          byp;
  } exp_t;

  exp_t sb_q[$];
  int n_cmp = 0;
  int n_err = 0;
  logic [N-1:0][CW-1:0] ec;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_sample(input logic [W-1:0] d, input int leff, input logic byp);
    exp_t e;
    for (int p = 0; p < leff; p++) begin
      e.data = (p == 0) ? d : '0;
      e.ph   = LW'(p);
      e.byp  = byp;
      sb_q.push_back(e);
    end
  endtask

  // Present a sample, wait (bounded) for acceptance; returns 1 ns after the
  // accepting edge with s_valid dropped.
  task automatic send(input logic [W-1:0] d, input int leff, input logic byp);
    int t = 0;
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.s_ready) break;
      t++;
      if (t > 500) begin
        n_cmp++; n_err++;
        $display("FAIL send_timeout: s_ready never rose for sample %0h", d);
        bus.s_valid = 1'b0;
        return;
      end
    end
    push_sample(d, leff, byp);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while (sb_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1;
    chk({nm, "_drain"}, 128'(sb_q.size()), 128'(0));
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [CW-1:0] d, input logic cm);
    coef_wr_en   = 1'b1;
    coef_wr_addr = a;
    coef_wr_data = d;
    coef_commit  = cm;
    @(posedge clk); #1;
    coef_wr_en  = 1'b0;
    coef_commit = 1'b0;
  endtask

  // Slot monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.m_valid && bus.m_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL slot_unexpected: got data=%0h phase=%0d", bus.m_data, phase);
        end else begin
          e = sb_q.pop_front();
          chk("slot", 128'({bus.m_data, phase, fir_bypass}), 128'({e.data, e.ph, e.byp}));
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_m_valid", 128'(bus.m_valid), 128'(0));
    chk("rst_m_data",  128'(bus.m_data),  128'(0));
    chk("rst_s_ready", 128'(bus.s_ready), 128'(1));
    chk("rst_busy",    128'(busy),        128'(0));
    chk("rst_coeff",   128'(fir_coeff),   128'(0));
    chk("rst_phase",   128'({phase, fir_bypass}), 128'(0));
    @(posedge clk); #1;

    // L=4 back-to-back samples, s_ready only on last slots
    cfg_l = 4'd4; bus.m_ready = 1'b1;
    bus.s_data = 16'd100; bus.s_valid = 1'b1;
    @(negedge clk);
    chk("t1_idle_ready", 128'(bus.s_ready), 128'(1));
    push_sample(16'd100, 4, 1'b0);
    @(posedge clk); #1;
    bus.s_data = 16'd200;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t1_m_valid", 128'(bus.m_valid), 128'(1));
      chk("t1_s_ready", 128'(bus.s_ready), 128'((k == 3) || (k == 7)));
      if (k == 3) push_sample(16'd200, 4, 1'b0);
      @(posedge clk); #1;
      if (k == 3) bus.s_valid = 1'b0;
    end
    chk("t1_idle_after", 128'(busy), 128'(0));
    drain("t1");

    // L=3 with a two-cycle stall on phase 1
    cfg_l = 4'd3;
    send(16'd50, 3, 1'b0);
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t2_hold_phase",  128'(phase),       128'(1));
      chk("t2_hold_data",   128'(bus.m_data),  128'(0));
      chk("t2_hold_valid",  128'(bus.m_valid), 128'(1));
      @(posedge clk); #1;
    end
    bus.m_ready = 1'b1;
    drain("t2");

    // cfg_l=0 -> one slot per sample; cfg_l=15 -> clamped to 8
    cfg_l = 4'd0;
    send(16'd7, 1, 1'b0);
    send(16'd8, 1, 1'b0);
    send(16'd9, 1, 1'b0);
    drain("t3a");
    cfg_l = 4'd15;
    send(16'h55, 8, 1'b0);
    drain("t3b");

    // Bypass latched per sample
    cfg_l = 4'd4; cfg_bypass = 1'b1;
    send(16'h33, 4, 1'b1);
    cfg_bypass = 1'b0;
    drain("t4a");
    chk("t4_bypass_held", 128'(fir_bypass), 128'(1));
    cfg_l = 4'd2;
    send(16'h44, 2, 1'b0);
    drain("t4b");

    // Shadow writes, commit mid-sample takes effect at last-slot handshake
    for (int i = 0; i < N; i++) begin
      wr(AW'(i), CW'(i + 1), 1'b0);
      ec[i] = CW'(i + 1);
    end
    wr(3'd6, 16'h77, 1'b0);
    @(negedge clk);
    chk("t5_active_untouched", 128'(fir_coeff), 128'(0));
    @(posedge clk); #1;
    cfg_l = 4'd4;
    send(16'h11, 4, 1'b0);
    @(posedge clk); #1;
    coef_commit = 1'b1;
    @(posedge clk); #1;
    coef_commit = 1'b0;
    @(negedge clk);
    chk("t5_phase2_old", 128'(fir_coeff), 128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_last_old", 128'(fir_coeff), 128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_swapped", 128'(fir_coeff), 128'(ec));
    drain("t5");

    // Write and commit same cycle in IDLE: swap takes pre-write shadow
    wr(3'd0, 16'd99, 1'b1);
    @(negedge clk);
    chk("t6_prewrite_swap", 128'(fir_coeff), 128'(ec));
    @(posedge clk); #1;
    coef_commit = 1'b1;
    @(posedge clk); #1;
    coef_commit = 1'b0;
    ec[0] = 16'd99;
    @(negedge clk);
    chk("t6_second_swap", 128'(fir_coeff), 128'(ec));
    @(posedge clk); #1;
    wr(3'd5, 16'h1234, 1'b0);
    wr(3'd7, 16'h4321, 1'b1);
    @(negedge clk);
    chk("t6_oob_ignored", 128'(fir_coeff), 128'(ec));
    @(posedge clk); #1;

    // Reset in the middle of a sample
    cfg_l = 4'd4;
    send(16'h66, 4, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t7_phase2", 128'({busy, phase}), 128'({1'b1, 4'd2}));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    sb_q.delete();
    @(negedge clk);
    chk("t7_m_valid", 128'(bus.m_valid), 128'(0));
    chk("t7_s_ready", 128'(bus.s_ready), 128'(1));
    chk("t7_coeff",   128'(fir_coeff),   128'(0));
    chk("t7_busy",    128'({busy, phase}), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    cfg_l = 4'd2;
    send(16'h21, 2, 1'b0);
    drain("t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fir_interp_ctrl.md
FIR_INTERP_CTRL -- requirements
Module: fir_interp_ctrl

Interface
REQ-001 Parameter INPUT_WORD_SIZE, default 16, sample width.
REQ-002 Parameter COEFF_WORD_SIZE, default 16, coefficient width.
REQ-003 Parameter N_COEFFS, default 5, number of FIR taps.
REQ-004 Parameter MAX_L, default 8, maximum upsample factor; LW = $clog2(MAX_L+1), AW = $clog2(N_COEFFS).
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 cfg_l  in  LW  upsample factor L.
REQ-008 cfg_bypass  in  1  requested FIR bypass.
REQ-009 coef_wr_en / coef_wr_addr / coef_wr_data  in  1 / AW / COEFF_WORD_SIZE  shadow-bank write port.
REQ-010 coef_commit  in  1  single-cycle request to swap shadow bank into active bank.
REQ-011 s_data / s_valid  in  INPUT_WORD_SIZE / 1; s_ready  out  1  upstream sample handshake.
REQ-012 m_data / m_valid  out  INPUT_WORD_SIZE / 1; m_ready  in  1  slot handshake toward FIR.
REQ-013 fir_coeff  out  N_COEFFS x COEFF_WORD_SIZE (packed, signed)  active coefficient bank.
REQ-014 fir_bypass  out  1  bypass in effect for current sample.
REQ-015 busy  out  1  high while in EMIT; phase  out  LW  current slot index.

Function
REQ-016 FSM states: IDLE, EMIT only.
REQ-017 IDLE: s_ready=1, m_valid=0; on s_valid, latch s_data, effective L (L_eff), cfg_bypass; phase<=0; go EMIT.
REQ-018 L_eff: cfg_l=0 -> 1; cfg_l>MAX_L -> MAX_L; else cfg_l; sampled only at sample acceptance.
REQ-019 EMIT: m_valid=1; m_data = latched sample when phase=0, else zero (zero-stuffing).
REQ-020 EMIT: m_data, m_valid, phase stable while m_ready=0 (no slot dropped or repeated).
REQ-021 EMIT: on m_ready with phase<L_eff-1, phase increments.
REQ-022 EMIT last slot (phase=L_eff-1): s_ready = m_ready (combinational); on m_ready with s_valid, accept new sample, stay EMIT, phase<=0 (zero-bubble back-to-back); on m_ready without s_valid, go IDLE.
REQ-023 s_ready=0 in EMIT except REQ-022 case; upstream throughput = 1 sample per L_eff slots.
REQ-024 fir_bypass holds value latched with current sample; mid-sample cfg_bypass changes ignored.
REQ-025 coef_wr_en writes shadow[coef_wr_addr] next edge; addr >= N_COEFFS ignored; active bank unaffected.
REQ-026 coef_commit sets commit_pending; sample boundary = any cycle in IDLE, or REQ-022 last-slot handshake; at boundary with pending, active<=shadow, pending cleared same edge.
REQ-027 Commit and boundary in same cycle: swap occurs that edge; write and swap same cycle: swap copies pre-write shadow, write lands in shadow.
REQ-028 fir_coeff driven directly from active-bank registers (no combinational path from write port).

Reset
REQ-029 rst: state IDLE, phase 0, latched sample 0, L_eff 1, fir_bypass 0, commit_pending 0, both banks all-zero.
REQ-030 Reset outputs: m_valid 0, m_data 0, s_ready 1 (first cycle after reset), busy 0, fir_coeff 0.
REQ-031 rst mid-EMIT aborts sample; in-progress slots discarded; rst overrides every other input same edge.

Structure
REQ-032 Package fir_interp_pkg holds FSM state enum and clamp function for L_eff.
REQ-033 One sub-module fir_coeff_bank (shadow + active registers, pending flag, swap); FSM top-level.

Verification
REQ-034 cfg_l=4, m_ready=1, samples 100,200 back-to-back -> m_data 100,0,0,0,200,0,0,0 on consecutive cycles, s_ready high only on slots 3 and 7.
REQ-035 cfg_l=3, m_ready low 2 cycles at phase 1 -> m_data 0, phase 1 held; sequence still 3 slots, no duplicates.
REQ-036 cfg_l=0 -> L_eff 1, every slot carries sample; cfg_l=15 (MAX_L=8) -> 8 slots per sample.
REQ-037 Write shadow 1..5, commit at phase 1 of L=4 sample -> fir_coeff unchanged until last-slot handshake, then 1..5 next cycle.
REQ-038 rst asserted at phase 2 -> next cycle m_valid 0, s_ready 1, fir_coeff 0, busy 0.
